axi_rd_arbiter: RTL

- Shares the single AXI-lite instruction/data SRAM read port between two read masters: IFU (master 0) and LSU (master 1).
- Grants one outstanding read at a time using 2-way round-robin arbitration.
- Steers the AR and R channels between the granted master and the SRAM slave.
- Sits between the IFU/LSU read interfaces and the SRAM slave. The write channels bypass this block.

---
 rtl/axi_rd_arbiter_pkg.sv | 16 +
 rtl/axi_rd_arbiter_rr_arb2.sv | 17 +
 rtl/axi_rd_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-master SRAM read arbiter.
// Holds FSM state encodings, response codes and master IDs.
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b11
  } state_e;

  localparam logic [2:0] RESP_OKAY = 3'b000;

  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin pick.
// Ports: req_i[1:0], last_grant_i -> gnt_id_o, gnt_valid_o.
module rr_arb2
  import axi_rd_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_id_o,
  output logic       gnt_valid_o
);

  assign gnt_valid_o = |req_i;

  // On a tie the master that did not win last time goes next.
  assign gnt_id_o = (&req_i) ? ~last_grant_i : req_i[M_LSU];

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one SRAM AXI-lite read port between IFU (0) and LSU (1),
// one outstanding read at a time, round-robin on ties.
// Ports: clk, rst (sync, active-high); ifu_* / lsu_* master AR+R
// channels; sram_* slave AR+R channels.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  input  logic [DATA_LEN-1:0] ifu_araddr,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  output logic [DATA_LEN-1:0] ifu_rdata,
  output logic [2:0]          ifu_rresp,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  input  logic [DATA_LEN-1:0] lsu_araddr,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  output logic [DATA_LEN-1:0] lsu_rdata,
  output logic [2:0]          lsu_rresp,
  output logic                sram_arvalid,
  input  logic                sram_arready,
  output logic [DATA_LEN-1:0] sram_araddr,
  input  logic                sram_rvalid,
  output logic                sram_rready,
  input  logic [DATA_LEN-1:0] sram_rdata,
  input  logic [2:0]          sram_rresp
);

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_q, last_d;

  logic   gnt_id, gnt_valid;

  logic                sel_arvalid;
  logic [DATA_LEN-1:0] sel_araddr;
  logic                sel_rready;
  logic                fwd_ar, fwd_r;

  rr_arb2 u_arb (
    .req_i        ({lsu_arvalid, ifu_arvalid}),
    .last_grant_i (last_q),
    .gnt_id_o     (gnt_id),
    .gnt_valid_o  (gnt_valid)
  );

  assign sel_arvalid = (grant_q == M_LSU) ? lsu_arvalid : ifu_arvalid;
  assign sel_araddr  = (grant_q == M_LSU) ? lsu_araddr  : ifu_araddr;
  assign sel_rready  = (grant_q == M_LSU) ? lsu_rready  : ifu_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= M_IFU;
      last_q  <= M_IFU;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    fwd_ar  = 1'b0;
    fwd_r   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          grant_d = gnt_id;
          last_d  = gnt_id;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        fwd_ar = 1'b1;
        fwd_r  = 1'b1;
        // Address and data may both complete in this one cycle.
        if (sram_arready) begin
          state_d = (sram_rvalid && sel_rready) ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        fwd_r = 1'b1;
        if (sram_rvalid && sel_rready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sram_arvalid = 1'b0;
    sram_araddr  = '0;
    sram_rready  = 1'b0;
    ifu_arready  = 1'b0;
    ifu_rvalid   = 1'b0;
    ifu_rdata    = '0;
    ifu_rresp    = RESP_OKAY;
    lsu_arready  = 1'b0;
    lsu_rvalid   = 1'b0;
    lsu_rdata    = '0;
    lsu_rresp    = RESP_OKAY;
    if (fwd_ar) begin
      sram_arvalid = sel_arvalid;
      sram_araddr  = sel_araddr;
      if (grant_q == M_LSU) lsu_arready = sram_arready;
      else                  ifu_arready = sram_arready;
    end
    if (fwd_r) begin
      sram_rready = sel_rready;
      if (grant_q == M_LSU) begin
        lsu_rvalid = sram_rvalid;
        lsu_rdata  = sram_rdata;
        lsu_rresp  = sram_rresp;
      end else begin
        ifu_rvalid = sram_rvalid;
        ifu_rdata  = sram_rdata;
        ifu_rresp  = sram_rresp;
      end
    end
  end

endmodule
